// File: rtl/dac_pkg.sv
// Shared types for the FIR output stage and the serial DAC link.
package dac_pkg;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } dac_state_t;

  localparam int FRAME_BITS = 16;

endpackage

// File: rtl/dac_serialiser_if.sv
// Sample handshake from the FIR plus the three-wire DAC link and status flags.
interface dac_serialiser_if;
  import dac_pkg::*;

  sample_t in;
  logic    input_ready;
  logic    sclk;
  logic    sdata;
  logic    sync_n;
  logic    overflow;
  logic    busy;

  modport master (
    output in, input_ready,
    input  sclk, sdata, sync_n, overflow, busy
  );

  modport slave (
    input  in, input_ready,
    output sclk, sdata, sync_n, overflow, busy
  );

endinterface

// File: rtl/dac_serialiser_fifo.sv
// sample_fifo: synchronous circular buffer of filtered samples.
module sample_fifo
  import dac_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    ck,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  sample_t din,
  output sample_t dout,
  output logic    full,
  output logic    empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  sample_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  always_ff @(posedge ck) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two; count separates full from empty.
  always_ff @(posedge ck) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/dac_serialiser.sv
// dac_serialiser: buffers FIR samples and shifts them MSB-first to a serial DAC.
// Define DAC_SERIALISER_OFFSET_BINARY_EN to send offset-binary instead of two's complement.
module dac_serialiser
  import dac_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int CLK_DIV = 4
) (
  input logic             ck,
  input logic             rst,
  dac_serialiser_if.slave bus
);

  localparam int             PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]  PHASE_LAST = PW'(CLK_DIV - 1);
  localparam logic [3:0]     BIT_LAST   = 4'(FRAME_BITS - 1);

  dac_state_t    state_q, state_d;
  logic [PW-1:0] phase_q;
  logic          half_q;
  logic [3:0]    bit_q;
  logic [15:0]   shift_q;
  logic [15:0]   load_word;
  sample_t       fifo_dout;
  logic          fifo_full, fifo_empty;
  logic          push, pop, phase_end;
  logic          sclk_q, sdata_q, sync_n_q, overflow_q;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts alongside a pop.
  assign push      = bus.input_ready & (~fifo_full | pop);
  assign phase_end = (phase_q == PHASE_LAST);

  sample_fifo #(.DEPTH(DEPTH)) u_fifo (
    .ck    (ck),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef DAC_SERIALISER_OFFSET_BINARY_EN
  assign load_word = {~fifo_dout[15], fifo_dout[14:0]};
`else
  assign load_word = fifo_dout;
`endif

  always_ff @(posedge ck) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (phase_end && half_q && (bit_q == BIT_LAST)) state_d = GAP;
      end
      GAP: begin
        if (phase_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // half_q selects the low/high half of each bit; shifting happens on the high-to-low transition.
  always_ff @(posedge ck) begin
    if (rst) begin
      phase_q <= '0;
      half_q  <= 1'b0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          phase_q <= '0;
          half_q  <= 1'b0;
          bit_q   <= '0;
          if (pop) shift_q <= load_word;
        end
        SHIFT: begin
          phase_q <= phase_end ? '0 : phase_q + PW'(1);
          if (phase_end) begin
            half_q <= ~half_q;
            if (half_q) begin
              shift_q <= {shift_q[14:0], 1'b0};
              bit_q   <= bit_q + 4'd1;
            end
          end
        end
        GAP: begin
          phase_q <= phase_end ? '0 : phase_q + PW'(1);
        end
        default: ;
      endcase
    end
  end

  // Link pins are registered together so sdata and sclk always move on the same edge.
  always_ff @(posedge ck) begin
    if (rst) begin
      sclk_q     <= 1'b0;
      sdata_q    <= 1'b0;
      sync_n_q   <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      sclk_q   <= (state_q == SHIFT) & half_q;
      sdata_q  <= (state_q == SHIFT) & shift_q[15];
      sync_n_q <= (state_q != SHIFT);
      if (bus.input_ready & fifo_full & ~pop) overflow_q <= 1'b1;
    end
  end

  assign bus.sclk     = sclk_q;
  assign bus.sdata    = sdata_q;
  assign bus.sync_n   = sync_n_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_dac_serialiser.sv
// Scoreboard bench for dac_serialiser: directed samples in, decoded serial frames checked out.
module tb_dac_serialiser;
  import dac_pkg::*;

  localparam int DEPTH        = 4;
  localparam int CLK_DIV      = 4;
  localparam int FRAME_LOW    = 2 * FRAME_BITS * CLK_DIV;
  localparam int FRAME_PERIOD = 33 * CLK_DIV + 1;

  logic ck  = 1'b0;
  logic rst = 1'b1;

  dac_serialiser_if bus ();

  dac_serialiser #(.DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  always #5 ck = ~ck;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] exp_q[$];
  int          frame_starts[$];

  logic        prev_sync  = 1'b1;
  logic        prev_sclk  = 1'b0;
  logic        prev_sdata = 1'b0;
  bit          in_frame   = 1'b0;
  logic [15:0] word       = '0;
  int          nbits      = 0;
  int          low_len    = 0;
  int          sclk_rises = 0;

  logic [15:0] ovf_vals [6];
  logic [15:0] mac_in   [3];
  logic [15:0] mac_exp  [3];

  always @(posedge ck) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] onWire(input logic [15:0] s);
`ifdef DAC_SERIALISER_OFFSET_BINARY_EN
    return {~s[15], s[14:0]};
`else
    return s;
`endif
  endfunction

  // Monitor: rebuilds each frame from the link and scores it against the expected queue.
  always @(negedge ck) begin
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      if (bus.sclk && !prev_sclk) sclk_rises++;
      if (!bus.sync_n && prev_sync) begin
        in_frame = 1'b1;
        word     = '0;
        nbits    = 0;
        low_len  = 0;
        frame_starts.push_back(cyc);
      end
      if (in_frame && !bus.sync_n) begin
        low_len++;
        if (bus.sclk && !prev_sclk) begin
          word = {word[14:0], bus.sdata};
          nbits++;
        end
      end
      if (bus.sclk && prev_sclk && (bus.sdata !== prev_sdata))
        checkOutput("sdata_stable_while_sclk_high", bus.sdata, prev_sdata);
      if (in_frame && bus.sync_n && !prev_sync) begin
        in_frame = 1'b0;
        checkOutput("frame_len", low_len, FRAME_LOW);
        checkOutput("frame_bits", nbits, FRAME_BITS);
        checkOutput("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) checkOutput("frame_data", word, exp_q.pop_front());
      end
    end
    prev_sync  = bus.sync_n;
    prev_sclk  = bus.sclk;
    prev_sdata = bus.sdata;
  end

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] sample, input bit accepted, input logic [15:0] exp_word);
    bus.in          = sample;
    bus.input_ready = 1'b1;
    tick();
    bus.input_ready = 1'b0;
    if (accepted) exp_q.push_back(exp_word);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_sclk"},     bus.sclk,     0);
    checkOutput({tag, "_sdata"},    bus.sdata,    0);
    checkOutput({tag, "_sync_n"},   bus.sync_n,   1);
    checkOutput({tag, "_overflow"}, bus.overflow, 0);
    checkOutput({tag, "_busy"},     bus.busy,     0);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic waitIdle(input int budget);
    int k = 0;
    while ((bus.busy || in_frame) && k < budget) begin
      tick();
      k++;
    end
    checkOutput("idle_reached", bus.busy | in_frame, 0);
    repeat (2) tick();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int strobe_c;
    int rises0;
    int frames0;
    int k;

    ovf_vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    mac_in   = '{16'h0000, 16'hFFFF, 16'h8000};
`ifdef DAC_SERIALISER_OFFSET_BINARY_EN
    mac_exp  = '{16'h8000, 16'h7FFF, 16'h0000};
`else
    mac_exp  = '{16'h0000, 16'hFFFF, 16'h8000};
`endif

    bus.in          = '0;
    bus.input_ready = 1'b0;
    resetDut();
    $display("[TB] power-on reset");
    checkResetOutputs("por");

    $display("[TB] single sample");
    frame_starts.delete();
    applyStimulus(16'h5A3C, 1'b1, onWire(16'h5A3C));
    strobe_c = cyc;
    waitIdle(400);
    checkOutput("single_frames", frame_starts.size(), 1);
    checkOutput("single_latency", (frame_starts.size() > 0) ? frame_starts[0] - strobe_c : -1, 2);

    $display("[TB] burst of three");
    frame_starts.delete();
    applyStimulus(16'h0001, 1'b1, onWire(16'h0001));
    applyStimulus(16'h8000, 1'b1, onWire(16'h8000));
    applyStimulus(16'h7FFF, 1'b1, onWire(16'h7FFF));
    waitIdle(1000);
    checkOutput("burst_frames", frame_starts.size(), 3);
    for (int i = 1; i < frame_starts.size(); i++)
      checkOutput("burst_spacing", frame_starts[i] - frame_starts[i-1], FRAME_PERIOD);

    $display("[TB] reset mid-frame");
    applyStimulus(16'h1234, 1'b0, 16'h0000);
    k = 0;
    while (bus.sync_n && k < 10) begin
      tick();
      k++;
    end
    checkOutput("midframe_sync_fell", bus.sync_n, 0);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    checkOutput("sync_n_after_rst_edge", bus.sync_n, 1);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    checkResetOutputs("midframe_rst");
    rises0  = sclk_rises;
    frames0 = frame_starts.size();
    repeat (200) tick();
    checkOutput("no_sclk_after_rst", sclk_rises - rises0, 0);
    checkOutput("no_frame_after_rst", frame_starts.size() - frames0, 0);
    checkOutput("busy_after_rst", bus.busy, 0);

    $display("[TB] overflow with six strobes");
    frame_starts.delete();
    for (int i = 0; i < 6; i++)
      applyStimulus(ovf_vals[i], i < 5, onWire(ovf_vals[i]));
    checkOutput("overflow_set", bus.overflow, 1);
    waitIdle(2000);
    checkOutput("overflow_frames", frame_starts.size(), 5);
    checkOutput("overflow_sticky", bus.overflow, 1);
    resetDut();
    checkOutput("overflow_cleared", bus.overflow, 0);

    $display("[TB] full FIFO with coincident pop");
    frame_starts.delete();
    applyStimulus(16'hA001, 1'b1, onWire(16'hA001));
    applyStimulus(16'hB002, 1'b1, onWire(16'hB002));
    applyStimulus(16'hC003, 1'b1, onWire(16'hC003));
    applyStimulus(16'hD004, 1'b1, onWire(16'hD004));
    applyStimulus(16'hE005, 1'b1, onWire(16'hE005));
    checkOutput("full_no_overflow_yet", bus.overflow, 0);
    repeat (FRAME_PERIOD - 4) tick();
    applyStimulus(16'hF006, 1'b1, onWire(16'hF006));
    checkOutput("full_pop_no_overflow", bus.overflow, 0);
    waitIdle(2000);
    checkOutput("full_pop_frames", frame_starts.size(), 6);

    $display("[TB] sign-bit coding vectors");
    frame_starts.delete();
    for (int i = 0; i < 3; i++)
      applyStimulus(mac_in[i], 1'b1, mac_exp[i]);
    waitIdle(1000);
    checkOutput("coding_frames", frame_starts.size(), 3);

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_serialiser.md
# dac_serialiser

Output stage placed directly downstream of the 16-tap FIR filter. It accepts each filtered 16-bit sample when the filter pulses its ready strobe, and buffers samples in a small FIFO. It then shifts every sample out MSB-first over a three-wire serial DAC link (sclk, sdata, sync_n). The FIFO absorbs the rate mismatch between the filter's burst output and the slower serial frame.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; must be a power of two, ≥2.
- CLK_DIV, 4, ck cycles per sclk half-period; must be ≥1.

Ports:
- ck  input  1  system clock; all logic is rising-edge.
- rst  input  1  reset, synchronous, active-high.
- in  input  16  signed sample from the FIR output register.
- input_ready  input  1  one-cycle strobe; `in` is valid in this cycle.
- sclk  output  1  serial clock to the DAC.
- sdata  output  1  serial data, MSB first.
- sync_n  output  1  frame strobe, active-low; low for the whole 16-bit frame.
- overflow  output  1  sticky flag: a sample was dropped because the FIFO was full.
- busy  output  1  high when the FIFO is non-empty or a frame is in progress.

## Operation
- **FIFO write:** when input_ready=1 and the FIFO is not full, `in` is written at the next edge.
- **FIFO full:** a strobe arriving while full is dropped and overflow is set. Overflow clears only on rst.
- **Push and pop in the same cycle while full:** both happen. The sample is accepted and overflow is not set.
- **FSM states:** IDLE, SHIFT, GAP.
  - **IDLE:** sclk=0, sync_n=1. If the FIFO is non-empty, pop the head into a 16-bit shift register and go to SHIFT.
  - **SHIFT:** sync_n=0 and sdata=shift[15]. Each bit lasts 2·CLK_DIV cycles: sclk is low for CLK_DIV cycles, then high for CLK_DIV cycles.
    - At the sclk falling edge ending a bit, the shift register shifts left by one.
    - A 4-bit bit counter and a clog2(CLK_DIV)-bit phase counter track position.
    - After the falling edge of bit 0 (the 16th bit), go to GAP.
  - **GAP:** sync_n=1, sclk=0, sdata=0 for CLK_DIV cycles, then go to IDLE.
- The DAC samples sdata on the sclk rising edge. sdata never changes while sclk is high.
- Samples are transmitted in arrival order. No sample is ever duplicated.
- busy = (state≠IDLE) | ~fifo_empty.

## Timing
- **Reset values:** sclk=0, sdata=0, sync_n=1, overflow=0, busy=0. The FSM goes to IDLE and the FIFO is emptied; pointers and count are set to 0.
- **rst mid-frame:** the frame is abandoned. sync_n=1 on the cycle after the reset edge. No partial frame resumes.
- **Latency:** with the block idle and the FIFO empty, input_ready sampled at edge N gives sync_n=0 from edge N+2.
- **Frame length:** sync_n is low for exactly 32·CLK_DIV cycles. sclk shows exactly 16 rising edges per frame.
- **Throughput:** back-to-back frames start every 33·CLK_DIV+1 cycles, which is 133 cycles at the default CLK_DIV.
- **Counter wrap:** the pointers wrap modulo DEPTH. The count distinguishes full (DEPTH) from empty (0).
- **Simultaneous push and pop while empty:** not possible, because a pop requires non-empty in the same cycle. The new sample waits for the next IDLE cycle.

## Configuration
- **DAC_SERIALISER_OFFSET_BINARY_EN:**
  - Defined: bit 15 of the popped sample is inverted before shifting. The result is offset-binary, e.g. 0x0000→0x8000 and 0x8000 (−32768)→0x0000.
  - Undefined: two's-complement bits are sent unchanged.

## Structure
- Package dac_pkg holds:
  - typedef sample_t (logic signed [15:0]), shared with the FIR.
  - enum dac_state_t {IDLE, SHIFT, GAP}.
  - localparam FRAME_BITS=16.
- Sub-module sample_fifo(DEPTH):
  - Synchronous circular buffer.
  - Ports: push, pop, din, dout, full, empty.
  - Reset through rst.
- The top level contains the FSM, the phase and bit counters, the shift register and the overflow flag.

## Test plan
- Reset: hold rst 3 cycles mid-frame (rst asserted 10 cycles after sync_n fell), then release -> sclk=0, sdata=0, sync_n=1, overflow=0, busy=0; no further sclk edges with FIFO empty.
- Single sample: in=0x5A3C strobed once, CLK_DIV=4 -> sync_n low 2 cycles later for 128 cycles; 16 sclk rising edges capture 0101101000111100.
- Burst: strobe 0x0001, 0x8000, 0x7FFF on consecutive cycles -> three frames in that order; sync_n falls spaced 133 cycles apart.
- Overflow: DEPTH=4, six strobes back-to-back while idle -> first pop leaves room for one more, so five samples are transmitted, the 6th is dropped, and overflow=1 until rst.
- Full plus pop: FIFO full and input_ready coincident with an IDLE pop -> sample accepted, overflow stays 0.
- Macro defined: in=0x0000 -> frame bits 1000000000000000; in=0xFFFF -> 0111111111111111.
